// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: state encoding,
// default frame parameters and a counter-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 32'd87;
  localparam int unsigned DEFAULT_DATA_BITS    = 32'd8;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous pad input; the reset value is a
// parameter so idle-high lines do not see a false edge out of reset.
module sync_chain #(
  parameter int unsigned STAGES    = 32'd2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the pad value through the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronised input, mid-bit sampling with a cycle counter,
// and a valid/ready holding register with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int unsigned SYNC_STAGES  = 32'd2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned   CW        = cnt_width(CLKS_PER_BIT);
  localparam int unsigned   IW        = cnt_width(DATA_BITS + 32'd1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 32'd2 - 32'd1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 32'd1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 32'd1);

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 arm_q, arm_d;
  logic                 rx_s;
  logic                 deliver_s;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_pin),
    .q_o   (rx_s)
  );

  // Frame sequencing plus delivery/consumption of the holding register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    deliver_s = 1'b0;
    // Arming needs a high line first so a line held low through reset cannot start a frame.
    arm_d     = arm_q | rx_s;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (arm_q && !rx_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver_s = 1'b1;
            state_d   = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          state_d = STOP;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    if (deliver_s) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
      arm_q   <= arm_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// scored against a queue of bytes the bench itself transmitted.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int TCLK = 10;
  localparam int TBIT = CPB * TCLK;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_pin;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  logic       pin15, pin17, aux_ready;
  logic [7:0] d15, d17;
  logic       v15, v17, fe15, fe17, ov15, ov17, b15, b17;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_deliv  = 0;
  int         n_ferr   = 0;
  int         n_ovr    = 0;
  int         n15      = 0;
  int         n17      = 0;
  logic [7:0] got15, got17;
  logic [7:0] exp_q[$];
  longint     t_fall   = 0;
  longint     t_valid  = 0;
  logic       prev_valid = 1'b0;

  always #(TCLK / 2) clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_pin), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  uart_rx #(.CLKS_PER_BIT(15), .DATA_BITS(8), .SYNC_STAGES(2)) u_dut15 (
    .clk(clk), .rst_n(rst_n), .rx_pin(pin15), .rx_data(d15), .rx_valid(v15),
    .rx_ready(aux_ready), .frame_err(fe15), .overrun(ov15), .busy(b15)
  );

  uart_rx #(.CLKS_PER_BIT(17), .DATA_BITS(8), .SYNC_STAGES(2)) u_dut17 (
    .clk(clk), .rst_n(rst_n), .rx_pin(pin17), .rx_data(d17), .rx_valid(v17),
    .rx_ready(aux_ready), .frame_err(fe17), .overrun(ov17), .busy(b17)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_pin(input int which, input logic v);
    case (which)
      0:       rx_pin = v;
      1:       pin15  = v;
      default: pin17  = v;
    endcase
  endtask

  // Transmit start, 8 data bits LSB first, and the given stop level.
  task automatic send_frame(input int which, input logic [7:0] b, input int bit_t,
                            input logic stop_bit);
    if (which == 0) t_fall = $time;
    set_pin(which, 1'b0);
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      set_pin(which, b[i]);
      #(bit_t);
    end
    set_pin(which, stop_bit);
    #(bit_t);
  endtask

  task automatic send_good(input logic [7:0] b, input int bit_t);
    exp_q.push_back(b);
    send_frame(0, b, bit_t, 1'b1);
  endtask

  task automatic wait_deliv(input int target, input int budget);
    int k = 0;
    while (n_deliv < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("delivery_count", 32'(n_deliv), 32'(target));
  endtask

  // Monitor: score every transfer and count error pulses.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rx_valid && !prev_valid) t_valid = $time;
      prev_valid = rx_valid;
      if (rx_valid && rx_ready) begin
        n_deliv++;
        check_eq("delivery_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("rx_data", 32'(rx_data), 32'(e));
        end
      end
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
      if (v15) begin got15 = d15; n15++; end
      if (v17) begin got17 = d17; n17++; end
    end
  end

  initial begin
    int d0, f0, o0, lat, exp_ferr, k;
    logic [7:0] rb;
    logic       rs;

    rst_n = 1'b0; rx_pin = 1'b1; pin15 = 1'b1; pin17 = 1'b1;
    rx_ready = 1'b1; aux_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_rx_data",   32'(rx_data),   32'd0);
    check_eq("rst_rx_valid",  32'(rx_valid),  32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    check_eq("rst_overrun",   32'(overrun),   32'd0);
    check_eq("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean frame with latency window.
    send_good(8'hA5, TBIT);
    wait_deliv(1, 50);
    lat = int'((t_valid - t_fall) / TCLK);
    check_eq("latency_window", 32'(lat >= 154 && lat <= 156), 32'd1);
    @(negedge clk);
    check_eq("clean_valid_dropped", 32'(rx_valid), 32'd0);
    check_eq("clean_data_held",     32'(rx_data),  32'hA5);
    check_eq("clean_busy_low",      32'(busy),     32'd0);
    check_eq("clean_no_ferr",       32'(n_ferr),   32'd0);
    check_eq("clean_no_ovr",        32'(n_ovr),    32'd0);

    // Back-to-back frames with no idle gap.
    send_good(8'h00, TBIT);
    send_good(8'hFF, TBIT);
    send_good(8'h55, TBIT);
    wait_deliv(4, 50);

    // Short low glitch must be rejected at the half-bit check.
    repeat (10) @(negedge clk);
    d0 = n_deliv;
    rx_pin = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("glitch_busy_high", 32'(busy), 32'd1);
    rx_pin = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("glitch_busy_low",  32'(busy),    32'd0);
    check_eq("glitch_no_deliv",  32'(n_deliv), 32'(d0));
    check_eq("glitch_no_ferr",   32'(n_ferr),  32'd0);

    // Framing error followed by a held-low line, then recovery.
    f0 = n_ferr;
    send_frame(0, 8'h3C, TBIT, 1'b0);
    repeat (100) @(negedge clk);
    check_eq("ferr_pulse_once", 32'(n_ferr),  32'(f0 + 1));
    check_eq("ferr_no_deliv",   32'(n_deliv), 32'(d0));
    check_eq("ferr_busy_break", 32'(busy),    32'd1);
    rx_pin = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("break_exit_idle", 32'(busy), 32'd0);
    send_good(8'h81, TBIT);
    wait_deliv(d0 + 1, 50);
    check_eq("after_ferr_data", 32'(rx_data), 32'h81);

    // Overrun while the consumer stalls.
    @(posedge clk); #2 rx_ready = 1'b0;
    send_frame(0, 8'h12, TBIT, 1'b1);
    exp_q.push_back(8'h12);
    k = 0;
    while (!rx_valid && k < 50) begin @(negedge clk); k++; end
    check_eq("stall_valid",  32'(rx_valid), 32'd1);
    check_eq("stall_data",   32'(rx_data),  32'h12);
    o0 = n_ovr;
    send_frame(0, 8'h34, TBIT, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("overrun_once",      32'(n_ovr),    32'(o0 + 1));
    check_eq("overrun_valid_held", 32'(rx_valid), 32'd1);
    check_eq("overrun_data_kept", 32'(rx_data),  32'h12);
    d0 = n_deliv;
    @(posedge clk); #2 rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("consume_valid_low", 32'(rx_valid), 32'd0);
    check_eq("consume_data_kept", 32'(rx_data),  32'h12);
    check_eq("consume_counted",   32'(n_deliv),  32'(d0 + 1));

    // Reset during data bit 3 of 0x96.
    repeat (10) @(negedge clk);
    rb = 8'h96;
    rx_pin = 1'b0;
    #(TBIT);
    for (int i = 0; i < 3; i++) begin rx_pin = rb[i]; #(TBIT); end
    rx_pin = rb[3];
    #(TBIT / 2);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_rx_data",   32'(rx_data),   32'd0);
    check_eq("midrst_rx_valid",  32'(rx_valid),  32'd0);
    check_eq("midrst_frame_err", 32'(frame_err), 32'd0);
    check_eq("midrst_overrun",   32'(overrun),   32'd0);
    check_eq("midrst_busy",      32'(busy),      32'd0);
    rx_pin = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    d0 = n_deliv; f0 = n_ferr;
    repeat (200) @(negedge clk);
    check_eq("postrst_no_deliv", 32'(n_deliv), 32'(d0));
    check_eq("postrst_no_ferr",  32'(n_ferr),  32'(f0));
    send_good(8'h69, TBIT);
    wait_deliv(d0 + 1, 50);
    check_eq("postrst_data", 32'(rx_data), 32'h69);

    // Baud error of about +/-3 percent.
    d0 = n_deliv;
    send_good(8'hA5, TBIT - 5);
    send_good(8'hA5, TBIT + 5);
    wait_deliv(d0 + 2, 50);

    // Receivers configured for 15- and 17-cycle bits.
    send_frame(1, 8'hA5, 15 * TCLK, 1'b1);
    send_frame(2, 8'hA5, 17 * TCLK, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("p15_count", 32'(n15), 32'd1);
    check_eq("p15_data",  32'(got15), 32'hA5);
    check_eq("p17_count", 32'(n17), 32'd1);
    check_eq("p17_data",  32'(got17), 32'hA5);

    // Randomized frames: random bytes, baud error, gaps and bad stop bits.
    d0 = n_deliv; f0 = n_ferr; o0 = n_ovr; exp_ferr = 0;
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 5) != 0);
      if (rs) begin
        send_good(rb, int'($urandom_range(TBIT - 5, TBIT + 5)));
        d0++;
      end else begin
        send_frame(0, rb, int'($urandom_range(TBIT - 5, TBIT + 5)), 1'b0);
        exp_ferr++;
        #(TBIT);
        rx_pin = 1'b1;
        #(2 * TCLK);
      end
      #(int'($urandom_range(0, 40)));
    end
    wait_deliv(d0, 100);
    check_eq("rand_ferr_count", 32'(n_ferr), 32'(f0 + exp_ferr));
    check_eq("rand_no_overrun", 32'(n_ovr),  32'(o0));
    check_eq("queue_drained",   32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
